// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding, default timings,
// and the baud divisor shared with the uart core.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } arb_state_t;

  localparam int unsigned WR_HOLD_DEF     = 10;
  localparam int unsigned BUSY_TO_DEF     = 1024;
  localparam int unsigned UART_BAUD_DIV   = 434;
  localparam int unsigned UART_FRAME_BITS = 10;

  // Clock cycles the uart core needs for one start/8-data/stop frame.
  function automatic int unsigned frame_cycles();
    return UART_FRAME_BITS * UART_BAUD_DIV;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first set request bit scanning rr, rr+1, ...
// modulo NREQ.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0] pos;

  // One extra bit on pos lets rr+i exceed NREQ-1 before the modulo fold.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = {1'b0, rr} + PW'(i);
      if (pos >= PW'(NREQ)) begin
        pos = pos - PW'(NREQ);
      end
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Optional busy-rise timeout with sticky err_o: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WR_HOLD = WR_HOLD_DEF,
  parameter int unsigned BUSY_TO = BUSY_TO_DEF
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [8*NREQ-1:0]       dat_i,
  output logic [NREQ-1:0]         ack_o,
  output logic                    tx_wr_o,
  output logic [7:0]              tx_dat_o,
  input  logic                    tx_busy_i,
  output logic [$clog2(NREQ)-1:0] gnt_id_o,
  output logic                    err_o
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned HW = $clog2(WR_HOLD + 1);

  arb_state_t    state;
  logic [IW-1:0] rr;
  logic [HW-1:0] hold_cnt;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          to_expired;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (req_i),
    .rr    (rr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(BUSY_TO + 1);

  logic [TW-1:0] to_cnt;

  // Counts WAIT_HI cycles; restarts from zero on every entry.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || state != ST_WAIT_HI) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_expired = (state == ST_WAIT_HI) && (to_cnt == TW'(BUSY_TO - 1));

  // Sticky until reset; a byte that never raised busy is not retried.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      err_o <= 1'b0;
    end else if (to_expired && !tx_busy_i) begin
      err_o <= 1'b1;
    end
  end
`else
  assign to_expired = 1'b0;
  assign err_o      = 1'b0;
`endif

  // Grant, strobe, then follow the uart busy flag through its rise and fall.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state    <= ST_IDLE;
      rr       <= '0;
      hold_cnt <= '0;
      ack_o    <= '0;
      tx_wr_o  <= 1'b0;
      tx_dat_o <= '0;
      gnt_id_o <= '0;
    end else begin
      ack_o <= '0;
      case (state)
        ST_IDLE: begin
          if (!tx_busy_i && pick_found) begin
            tx_dat_o <= dat_i[{pick_idx, 3'b000} +: 8];
            gnt_id_o <= pick_idx;
            ack_o    <= NREQ'(1) << pick_idx;
            rr       <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            hold_cnt <= '0;
            state    <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (hold_cnt == HW'(WR_HOLD)) begin
            tx_wr_o <= 1'b0;
            state   <= ST_WAIT_HI;
          end else begin
            tx_wr_o  <= 1'b1;
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (tx_busy_i) begin
            state <= ST_WAIT_LO;
          end else if (to_expired) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple uart busy model.
// Define UART_ARB_TIMEOUT_EN to also exercise the busy-rise timeout.
module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int WR_HOLD  = 10;
  localparam int BUSY_TO  = 64;
  localparam int BUSY_LEN = 30;

  logic        clk;
  logic        sys_rst_i;
  logic [3:0]  req_i;
  logic [31:0] dat_i;
  logic [3:0]  ack_o;
  logic        tx_wr_o;
  logic [7:0]  tx_dat_o;
  logic        tx_busy_i;
  logic [1:0]  gnt_id_o;
  logic        err_o;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .WR_HOLD (WR_HOLD),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (sys_rst_i),
    .req_i     (req_i),
    .dat_i     (dat_i),
    .ack_o     (ack_o),
    .tx_wr_o   (tx_wr_o),
    .tx_dat_o  (tx_dat_o),
    .tx_busy_i (tx_busy_i),
    .gnt_id_o  (gnt_id_o),
    .err_o     (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         id;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // uart model state, owned by the stimulus process
  int   uart_cnt   = 0;
  bit   uart_en    = 1'b1;
  bit   busy_force = 1'b0;
  bit   prev_wr    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id  = id;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  // One cycle: requesters drop acked bits, uart raises busy on a write strobe.
  task automatic tick();
    @(negedge clk);
    req_i = req_i & ~ack_o;
    if (uart_cnt != 0) uart_cnt--;
    if (uart_en && tx_wr_o && !prev_wr) uart_cnt = BUSY_LEN;
    prev_wr   = tx_wr_o;
    tx_busy_i = busy_force | (uart_cnt != 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_busy_force(input bit v);
    busy_force = v;
    tx_busy_i  = busy_force | (uart_cnt != 0);
  endtask

  task automatic wait_ack(input string name, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ack_o == 4'b0 && lat < 300);
    if (ack_o == 4'b0) begin
      total++;
      bad++;
      $display("FAIL %s: no ack within %0d cycles", name, lat);
    end
  endtask

  task automatic reset_dut();
    sys_rst_i = 1'b1;
    ticks(3);
    sys_rst_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every ack and checks each write strobe.
  logic [7:0] cur_byte = 8'h00;
  int         wr_len   = 0;
  bit         abort    = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sys_rst_i) abort = 1'b1;
      if (ack_o != 4'b0) begin
        chk("ack_onehot", 32'($onehot(ack_o)), 32'd1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack=0x%0h want none", ack_o);
        end else begin
          e = exp_q.pop_front();
          chk("ack_bits", 32'(ack_o), 32'(4'b0001 << e.id));
          chk("gnt_id", 32'(gnt_id_o), 32'(e.id));
          chk("tx_dat_at_ack", 32'(tx_dat_o), 32'(e.dat));
          cur_byte = e.dat;
        end
        abort = 1'b0;
      end
      if (tx_wr_o) begin
        wr_len++;
      end else begin
        if (wr_len != 0 && !abort) begin
          chk("wr_len", 32'(wr_len), 32'(WR_HOLD));
          chk("tx_dat_at_wr", 32'(tx_dat_o), 32'(cur_byte));
        end
        wr_len = 0;
      end
    end
  end

  initial begin
    int lat;
    int n;
    int acks;
    int ack_cyc[4];
    int prev_busy;

    sys_rst_i = 1'b1;
    req_i     = 4'b0;
    dat_i     = 32'h0;
    tx_busy_i = 1'b0;
    ticks(3);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_wr", 32'(tx_wr_o), 32'd0);
    chk("rst_dat", 32'(tx_dat_o), 32'd0);
    chk("rst_gnt", 32'(gnt_id_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    sys_rst_i = 1'b0;
    ticks(2);

    // single request
    push(0, 8'h1B);
    dat_i[7:0] = 8'h1B;
    req_i      = 4'b0001;
    wait_ack("single", lat);
    chk("single_lat", 32'(lat), 32'd1);
    tick();
    chk("single_wr_rise", 32'(tx_wr_o), 32'd1);
    ticks(60);

    // contention, starting from rr = 0
    reset_dut();
    ticks(2);
    push(0, 8'hA0); push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3);
    dat_i = 32'hA3A2A1A0;
    req_i = 4'b1111;
    acks  = 0;
    n     = 0;
    while (acks < 4 && n < 1000) begin
      tick();
      n++;
      if (ack_o != 4'b0) begin
        ack_cyc[acks] = n;
        acks++;
      end
    end
    chk("cont_acks", 32'(acks), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < acks) chk("cont_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(1 + WR_HOLD + 1 + BUSY_LEN - 9));
    end
    ticks(60);

    // fairness wrap: rr back at 0 after granting 3, then 3 after granting 0
    push(0, 8'hB0); push(3, 8'hB3);
    dat_i = 32'hB30000B0;
    req_i = 4'b1001;
    wait_ack("wrap0", lat);
    wait_ack("wrap3", lat);
    chk("wrap3_lat", 32'(lat), 32'(1 + WR_HOLD + 1 + BUSY_LEN - 9));
    ticks(60);

    // busy already high in IDLE
    set_busy_force(1'b1);
    push(1, 8'hC1);
    dat_i = 32'h0000C100;
    req_i = 4'b0010;
    acks  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack_o != 4'b0) acks++;
    end
    chk("busy_hold_noack", 32'(acks), 32'd0);
    set_busy_force(1'b0);
    wait_ack("busy_release", lat);
    chk("busy_release_lat", 32'(lat), 32'd1);
    ticks(60);

    // reset five cycles into the strobe with another request pending
    push(2, 8'hD2);
    dat_i = 32'h00D20000;
    req_i = 4'b0100;
    wait_ack("rst_strobe_grant", lat);
    ticks(5);
    chk("pre_rst_wr", 32'(tx_wr_o), 32'd1);
    sys_rst_i = 1'b1;
    push(3, 8'hE3);
    dat_i = 32'hE3000000;
    req_i = 4'b1000;
    tick();
    chk("mid_rst_wr", 32'(tx_wr_o), 32'd0);
    chk("mid_rst_dat", 32'(tx_dat_o), 32'd0);
    chk("mid_rst_gnt", 32'(gnt_id_o), 32'd0);
    tick();
    sys_rst_i = 1'b0;
    n = 0;
    prev_busy = 1;
    do begin
      prev_busy = int'(tx_busy_i);
      tick();
      n++;
    end while (ack_o == 4'b0 && n < 300);
    chk("post_rst_busy_low", 32'(prev_busy), 32'd0);
    chk("post_rst_wait", 32'(n), 32'd25);
    ticks(60);

`ifdef UART_ARB_TIMEOUT_EN
    // busy never rises: timeout, sticky error, then normal service
    uart_en = 1'b0;
    push(0, 8'h5A);
    dat_i = 32'h0000005A;
    req_i = 4'b0001;
    wait_ack("to_grant", lat);
    n = 0;
    while (!tx_wr_o && n < 50) begin tick(); n++; end
    while (tx_wr_o && n < 50) begin tick(); n++; end
    n = 0;
    while (!err_o && n < 200) begin tick(); n++; end
    chk("to_delay", 32'(n), 32'(BUSY_TO));
    chk("to_gnt", 32'(gnt_id_o), 32'd0);
    uart_en = 1'b1;
    push(1, 8'h6B);
    dat_i = 32'h00006B00;
    req_i = 4'b0010;
    wait_ack("to_next", lat);
    chk("to_next_lat", 32'(lat), 32'd1);
    ticks(60);
    chk("to_err_sticky", 32'(err_o), 32'd1);
`else
    chk("err_tied", 32'(err_o), 32'd0);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `NREQ` byte producers. It latches the winning requester's byte and strobes the UART write input for a fixed hold time. It then tracks the UART busy flag through its rise and fall before it grants the next requester. The block sits between the system-side producers (debug console, status reporter, command responder) and the `uart` core's `uart_wr_i` / `uart_dat_i` / `uart_busy` pins.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `WR_HOLD`, default 10: cycles `tx_wr_o` stays high per byte.
- `BUSY_TO`, default 1024: cycles allowed for `tx_busy_i` to rise after the strobe ends. Used only with the timeout feature.

Ports:
- `sys_clk_i`, in, 1: system clock; all logic is on its rising edge.
- `sys_rst_i`, in, 1: synchronous reset, active-high.
- `req_i`, in, `NREQ`: per-requester request level; held high until acked.
- `dat_i`, in, `8*NREQ`: byte k is `dat_i[8k+7:8k]`; valid whenever `req_i[k]` is high.
- `ack_o`, out, `NREQ`: one-cycle pulse; byte k latched, requester may drop or change its data.
- `tx_wr_o`, out, 1: goes to `uart_wr_i`.
- `tx_dat_o`, out, 8: goes to `uart_dat_i`; held stable from grant until the return to IDLE.
- `tx_busy_i`, in, 1: from `uart_busy`.
- `gnt_id_o`, out, `$clog2(NREQ)`: index of the current or last grant.
- `err_o`, out, 1: sticky busy-timeout flag.

## Operation

- Reset values:
  - state IDLE
  - `ack_o` = 0, `tx_wr_o` = 0, `tx_dat_o` = 0, `gnt_id_o` = 0, `err_o` = 0
  - round-robin pointer `rr` = 0; the highest priority goes to index 0.
- States: IDLE, STROBE, WAIT_HI, WAIT_LO.
- IDLE:
  - Waits until `tx_busy_i` == 0 and any `req_i` bit is set.
  - Winner = first set bit scanning `rr`, `rr+1`, … modulo `NREQ`.
  - In that cycle: latch `dat_i` byte into `tx_dat_o`, set `gnt_id_o`, pulse `ack_o[winner]`, set `rr` = winner+1 mod `NREQ`, go to STROBE.
- STROBE:
  - `tx_wr_o` = 1 for exactly `WR_HOLD` cycles, counted by the hold counter.
  - Then `tx_wr_o` = 0 and go to WAIT_HI.
- WAIT_HI:
  - `tx_busy_i` == 1 moves to WAIT_LO.
  - `tx_busy_i` already high during STROBE is also accepted: WAIT_HI exits on the first high sample.
- WAIT_LO: `tx_busy_i` == 0 moves to IDLE.
- Requests arriving while not in IDLE wait; they are never dropped.
- A requester that drops `req_i` before its ack is simply not granted. This is legal.
- The arbitration width is `NREQ` bits; the pointer wraps from `NREQ-1` to 0.
- Only one `ack_o` bit is ever set in a cycle.

## Timing

- Request to ack: `req_i` sampled high in IDLE; `ack_o` and the `tx_dat_o` update are registered 1 cycle later.
- `tx_wr_o` rises the cycle after the ack and is high for `WR_HOLD` cycles.
- Minimum byte-to-byte spacing is `1 + WR_HOLD + 1` cycles plus the UART busy time. That is about 10 bit times: 4340 cycles at 50 MHz / 115200 baud.
- Back-to-back requests: the next grant is issued in the cycle after WAIT_LO sees busy low.
- Reset mid-operation: on the next edge, state is IDLE and `tx_wr_o` = 0. A partially sent UART frame completes in the UART; the arbiter's first grant after reset waits for `tx_busy_i` low.

## Configuration

- Macro `UART_ARB_TIMEOUT_EN`, when defined:
  - WAIT_HI counts cycles.
  - If `tx_busy_i` is still low after `BUSY_TO` cycles: go to IDLE, set `err_o` (cleared only by reset), and keep `gnt_id_o` pointing at the failed requester.
  - The failed byte is not retried.
- When undefined: WAIT_HI waits indefinitely, the timeout counter is absent, and `err_o` is tied 0.

## Structure

- Shared package holds:
  - the state encoding constants (IDLE=0, STROBE=1, WAIT_HI=2, WAIT_LO=3)
  - the default `WR_HOLD` and `BUSY_TO` values
  - the baud divisor constant 434 shared with the `uart` core.
- One sub-module, `rr_pick`: combinational round-robin priority select.
  - Inputs: `req`, `rr`.
  - Outputs: `found`, `idx`.
- The FSM, counters, and output registers live in `uart_tx_arbiter`.

## Test plan

- Single request: `req_i`=4'b0001, byte 0x1B.
  - `ack_o[0]` pulses 1 cycle after the request.
  - `tx_wr_o` is high 10 cycles with `tx_dat_o`=0x1B.
  - The decoded `uart_tx` frame is 0x1B.
- Contention: `req_i`=4'b1111 with bytes 0xA0..0xA3 held until acked.
  - Grants go in order 0, 1, 2, 3.
  - Each ack occurs only after the prior frame's busy falls.
- Fairness wrap:
  - After granting 3, set `req_i`=4'b1001 → grant 0.
  - With `rr`=1 and `req_i`=4'b1001 → grant 3.
- Reset mid-STROBE: assert `sys_rst_i` 5 cycles into the strobe.
  - `tx_wr_o`=0 and state is IDLE at the next edge.
  - A pending request is granted only after `tx_busy_i` falls.
- Timeout (`UART_ARB_TIMEOUT_EN`, `BUSY_TO`=64): with `tx_busy_i` stuck at 0:
  - `err_o` rises 64 cycles after the strobe ends and `gnt_id_o` holds the requester index.
  - The arbiter serves the next request.
- Busy already high: hold `tx_busy_i`=1 in IDLE with `req_i`=4'b0010 → no ack until `tx_busy_i`=0, then the ack comes 1 cycle later.
